rsa_core_ctrl: RTL and testbench
================================

RSA_CORE_CTRL -- requirements
Module: rsa_core_ctrl

Interface
REQ-001 Parameter: WIDTH, default 256, operand width in bits; the block SHALL be verified at 256 only.
REQ-002 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_start  in  1  one-cycle request to begin y^d mod N.
REQ-005 i_n  in  256  modulus N, odd, N > 1.
REQ-006 i_y  in  256  base y, y < N.
REQ-007 i_d  in  256  exponent d.
REQ-008 o_busy  out  1  high from the cycle after accepted i_start until o_finished.
REQ-009 o_result  out  256  y^d mod N, valid when o_finished is high and held until the next accepted start.
REQ-010 o_finished  out  1  one-cycle completion pulse.
REQ-011 o_prep_start  out  1  one-cycle start to the preprocessing unit.
REQ-012 o_prep_n, o_prep_b  out  256  N and y to the preprocessing unit.
REQ-013 o_prep_a  out  257  constant 2^256; o_prep_k  out  9  constant 9'd256.
REQ-014 i_prep_done  in  1  pulse; i_prep_m  in  256  y*2^256 mod N.
REQ-015 o_mont_start  out  1  one-cycle start to the shared Montgomery multiplier.
REQ-016 o_mont_n, o_mont_a, o_mont_b  out  256  N and the two operands.
REQ-017 i_mont_done  in  1  pulse; i_mont_m  in  256  a*b*2^-256 mod N.

Function
REQ-018 States SHALL be IDLE, PREP_WAIT, MUL_WAIT, SQR_WAIT and DONE, encoded in a 3-bit register.
REQ-019 In IDLE, i_start SHALL latch i_n, i_y and i_d into internal registers, set m=1 and bit index i=0, pulse o_prep_start on the next cycle, and enter PREP_WAIT.
REQ-020 In PREP_WAIT, i_prep_done SHALL load t=i_prep_m and enter bit processing.
REQ-021 Bit processing: if d[i]=1, the block SHALL pulse o_mont_start with a=m, b=t and enter MUL_WAIT; otherwise it SHALL go straight to squaring.
REQ-022 In MUL_WAIT, i_mont_done SHALL load m=i_mont_m and proceed to squaring.
REQ-023 Squaring SHALL pulse o_mont_start with a=t, b=t and enter SQR_WAIT.
REQ-024 In SQR_WAIT, i_mont_done SHALL load t=i_mont_m; if i=255 the block SHALL enter DONE, otherwise i SHALL increment (9-bit counter) and bit processing SHALL repeat.
REQ-025 In DONE, the block SHALL drive o_result=m and pulse o_finished for one cycle, then return to IDLE.
REQ-026 Exactly one start pulse SHALL be outstanding at a time; o_prep_start and o_mont_start SHALL never be high in the same cycle.
REQ-027 o_mont_a, o_mont_b and o_mont_n SHALL remain stable from the start pulse until the matching done pulse.
REQ-028 i_start while o_busy=1 SHALL be ignored, and the latched operands SHALL be unaffected.
REQ-029 A done pulse arriving in any state other than its matching wait state SHALL be ignored.
REQ-030 Done pulses SHALL not time out; the block SHALL wait indefinitely in a wait state.
REQ-031 d=0 SHALL produce o_result=1; total Montgomery starts per job SHALL equal popcount(d)+256.
REQ-032 i_start in the same cycle as the DONE->IDLE transition SHALL be ignored; acceptance SHALL happen only in IDLE.

Reset
REQ-033 While i_rst=1 at a clock edge, the state SHALL become IDLE, i=0 and m=1, and o_busy, o_finished, o_prep_start and o_mont_start SHALL be 0.
REQ-034 While i_rst=1 at a clock edge, o_result SHALL become 0.
REQ-035 Reset mid-job SHALL abandon the job; done pulses arriving afterwards SHALL be ignored.
REQ-036 After reset, the next i_start SHALL run a fresh job with correct results.

Verification
REQ-037 Use behavioural prep/Montgomery models with random 1-20 cycle latency; N=33, y=5, d=3, start -> o_result=26, one o_finished pulse, 258 mont starts.
REQ-038 N=33, y=7, d=0 -> o_result=1, 256 mont starts, and no multiply-phase start.
REQ-039 Start while busy with different operands -> first job result unchanged and second request dropped.
REQ-040 Assert i_rst during SQR_WAIT, then deliver a stale i_mont_done -> block stays in IDLE with all outputs at reset values; a new job (N=33, y=2, d=5) -> 32.
REQ-041 Random 256-bit odd N, y<N and random d over 20 jobs -> o_result matches the reference model.
REQ-042 Spurious i_mont_done in IDLE or PREP_WAIT -> no state change, verified by assertion.

Source files
------------

// File: rtl/rsa_core_ctrl.sv
// rsa_core_ctrl: sequences right-to-left Montgomery square-and-multiply for y^d mod N over external prep/multiplier units
module rsa_core_ctrl #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished,
  output logic             o_prep_start,
  output logic [WIDTH-1:0] o_prep_n,
  output logic [WIDTH-1:0] o_prep_b,
  output logic [WIDTH:0]   o_prep_a,
  output logic [8:0]       o_prep_k,
  input  logic             i_prep_done,
  input  logic [WIDTH-1:0] i_prep_m,
  output logic             o_mont_start,
  output logic [WIDTH-1:0] o_mont_n,
  output logic [WIDTH-1:0] o_mont_a,
  output logic [WIDTH-1:0] o_mont_b,
  input  logic             i_mont_done,
  input  logic [WIDTH-1:0] i_mont_m
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP_WAIT, MUL_WAIT, SQR_WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, y_q, y_d, d_q, d_d, m_q, m_d, t_q, t_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [8:0] idx_q, idx_d;
  logic busy_q, busy_d, fin_q, fin_d, prep_q, prep_d, mont_q, mont_d;
  logic bit_go, sqr_go;
  logic [IW-1:0] j;
  logic [WIDTH-1:0] tv;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    y_d = y_q;
    d_d = d_q;
    m_d = m_q;
    t_d = t_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    idx_d = idx_q;
    busy_d = busy_q;
    fin_d = 1'b0;
    prep_d = 1'b0;
    mont_d = 1'b0;
    bit_go = 1'b0;
    sqr_go = 1'b0;
    j = idx_q[IW-1:0];
    tv = t_q;
    case (state_q)
      IDLE: if (i_start) begin
        n_d = i_n;
        y_d = i_y;
        d_d = i_d;
        m_d = WIDTH'(1);
        idx_d = '0;
        prep_d = 1'b1;
        busy_d = 1'b1;
        state_d = PREP_WAIT;
      end
      PREP_WAIT: if (i_prep_done) begin
        t_d = i_prep_m;
        tv = i_prep_m;
        bit_go = 1'b1;
      end
      MUL_WAIT: if (i_mont_done) begin
        m_d = i_mont_m;
        sqr_go = 1'b1;
      end
      SQR_WAIT: if (i_mont_done) begin
        t_d = i_mont_m;
        if (idx_q == 9'(WIDTH-1)) state_d = DONE;
        else begin
          idx_d = idx_q + 9'd1;
          j = idx_d[IW-1:0];
          tv = i_mont_m;
          bit_go = 1'b1;
        end
      end
      DONE: begin
        result_d = m_q;
        fin_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bit_go) begin
      mont_d = 1'b1;
      a_d = d_q[j] ? m_q : tv;
      b_d = tv;
      state_d = d_q[j] ? MUL_WAIT : SQR_WAIT;
    end
    if (sqr_go) begin
      mont_d = 1'b1;
      a_d = t_q;
      b_d = t_q;
      state_d = SQR_WAIT;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      n_q <= '0;
      y_q <= '0;
      d_q <= '0;
      m_q <= WIDTH'(1);
      t_q <= '0;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      fin_q <= 1'b0;
      prep_q <= 1'b0;
      mont_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      y_q <= y_d;
      d_q <= d_d;
      m_q <= m_d;
      t_q <= t_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      fin_q <= fin_d;
      prep_q <= prep_d;
      mont_q <= mont_d;
    end
  end
  assign o_busy = busy_q;
  assign o_result = result_q;
  assign o_finished = fin_q;
  assign o_prep_start = prep_q;
  assign o_prep_n = n_q;
  assign o_prep_b = y_q;
  assign o_prep_a = {1'b1, {WIDTH{1'b0}}};
  assign o_prep_k = 9'(WIDTH);
  assign o_mont_start = mont_q;
  assign o_mont_n = n_q;
  assign o_mont_a = a_q;
  assign o_mont_b = b_q;
endmodule

// File: tb/tb_rsa_core_ctrl.sv
// tb_rsa_core_ctrl: random-latency prep/Montgomery models around the controller, checked against plain modular exponentiation
module tb_rsa_core_ctrl;
  localparam int W = 256;
  logic i_clk = 0, i_rst = 1, i_start = 0;
  logic [W-1:0] i_n = '0, i_y = '0, i_d = '0;
  logic o_busy, o_finished, o_prep_start, o_mont_start;
  logic [W-1:0] o_result, o_prep_n, o_prep_b, o_mont_n, o_mont_a, o_mont_b;
  logic [W:0] o_prep_a;
  logic [8:0] o_prep_k;
  logic i_prep_done, i_mont_done;
  logic [W-1:0] i_prep_m, i_mont_m;
  int total = 0, bad = 0;
  int mont_cnt = 0, neq_cnt = 0, prep_cnt = 0, fin_cnt = 0;
  int max_lat = 20;
  bit prep_en = 1, mont_en = 1;
  int prep_req = 0, mont_req = 0;
  logic [W-1:0] prep_val, mont_val;

  rsa_core_ctrl #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_n(i_n), .i_y(i_y), .i_d(i_d),
    .o_busy(o_busy), .o_result(o_result), .o_finished(o_finished),
    .o_prep_start(o_prep_start), .o_prep_n(o_prep_n), .o_prep_b(o_prep_b),
    .o_prep_a(o_prep_a), .o_prep_k(o_prep_k), .i_prep_done(i_prep_done), .i_prep_m(i_prep_m),
    .o_mont_start(o_mont_start), .o_mont_n(o_mont_n), .o_mont_a(o_mont_a), .o_mont_b(o_mont_b),
    .i_mont_done(i_mont_done), .i_mont_m(i_mont_m)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] prep_f(input logic [W-1:0] y, input logic [W-1:0] n);
    logic [2*W-1:0] t, nn;
    t = {y, {W{1'b0}}};
    nn = {{W{1'b0}}, n};
    t = t % nn;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] mont_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
    logic [W+1:0] s;
    s = '0;
    for (int k = 0; k < W; k++) begin
      if (a[k]) s = s + {2'b00, b};
      if (s[0]) s = s + {2'b00, n};
      s = s >> 1;
    end
    if (s >= {2'b00, n}) s = s - {2'b00, n};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] modexp(input logic [W-1:0] n, input logic [W-1:0] y, input logic [W-1:0] d);
    logic [2*W-1:0] r, b, nn;
    r = 1;
    b = {{W{1'b0}}, y};
    nn = {{W{1'b0}}, n};
    for (int k = 0; k < W; k++) begin
      if (d[k]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[W-1:0];
  endfunction

  initial forever begin
    @(posedge i_clk);
    #2;
    if (o_mont_start) begin
      mont_cnt++;
      if (o_mont_a !== o_mont_b) neq_cnt++;
    end
    if (o_prep_start) prep_cnt++;
    if (o_finished) fin_cnt++;
  end

  initial begin : prep_model
    int seen;
    logic [W-1:0] pn, pb;
    seen = 0;
    i_prep_done = 0;
    i_prep_m = '0;
    forever begin
      @(negedge i_clk);
      i_prep_done = 0;
      if (o_prep_start && prep_en) begin
        pn = o_prep_n;
        pb = o_prep_b;
        chk("prep_mont_exclusive", W'(o_mont_start), '0);
        repeat ($urandom_range(1, max_lat)) @(negedge i_clk);
        i_prep_done = 1;
        i_prep_m = prep_f(pb, pn);
      end else if (prep_req != seen) begin
        seen++;
        i_prep_done = 1;
        i_prep_m = prep_val;
      end
    end
  end

  initial begin : mont_model
    int seen;
    logic [W-1:0] ma, mb, mn;
    seen = 0;
    i_mont_done = 0;
    i_mont_m = '0;
    forever begin
      @(negedge i_clk);
      i_mont_done = 0;
      if (o_mont_start && mont_en) begin
        ma = o_mont_a;
        mb = o_mont_b;
        mn = o_mont_n;
        chk("mont_prep_exclusive", W'(o_prep_start), '0);
        repeat ($urandom_range(1, max_lat)) @(negedge i_clk);
        chk("mont_a_stable", o_mont_a, ma);
        chk("mont_b_stable", o_mont_b, mb);
        chk("mont_n_stable", o_mont_n, mn);
        i_mont_done = 1;
        i_mont_m = mont_f(ma, mb, mn);
      end else if (mont_req != seen) begin
        seen++;
        i_mont_done = 1;
        i_mont_m = mont_val;
      end
    end
  end

  initial begin : spurious_mon
    logic [2:0] sp;
    bit cp;
    cp = 0;
    sp = '0;
    forever begin
      @(negedge i_clk);
      #1;
      if (cp) chk("spurious_done_ignored", W'(dut.state_q), W'(sp));
      sp = dut.state_q;
      cp = i_mont_done && !i_rst && !i_start && !i_prep_done && (dut.state_q == 3'd0 || dut.state_q == 3'd1);
    end
  end

  task automatic start_job(input logic [W-1:0] n, input logic [W-1:0] y, input logic [W-1:0] d);
    @(negedge i_clk);
    i_n = n;
    i_y = y;
    i_d = d;
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    i_n = rnd();
    i_y = rnd();
    i_d = rnd();
    chk("busy_after_start", W'(o_busy), W'(1));
  endtask

  task automatic wait_fin(output logic [W-1:0] res);
    int k = 0;
    while (!o_finished && k < 20000) begin
      @(negedge i_clk);
      k++;
    end
    chk("finish_seen", W'(o_finished), W'(1));
    chk("busy_low_at_finish", W'(o_busy), '0);
    res = o_result;
  endtask

  task automatic wait_cnt(input bit sel, input int target, input string tag);
    int k = 0;
    while ((sel ? mont_cnt : prep_cnt) < target && k < 500) begin
      @(negedge i_clk);
      k++;
    end
    chk(tag, W'((sel ? mont_cnt : prep_cnt) >= target), W'(1));
  endtask

  task automatic run_job(input logic [W-1:0] n, input logic [W-1:0] y, input logic [W-1:0] d,
                         input bit inject, input bit late_start,
                         output logic [W-1:0] res, output int ms, output int nq);
    int mb, qb, fb, pb, exp_starts, k;
    mb = mont_cnt;
    qb = neq_cnt;
    fb = fin_cnt;
    pb = prep_cnt;
    exp_starts = $countones(d) + W;
    start_job(n, y, d);
    if (inject) begin
      repeat (5) @(negedge i_clk);
      i_n = 33;
      i_y = 4;
      i_d = 7;
      i_start = 1;
      @(negedge i_clk);
      i_start = 0;
    end
    if (late_start) begin
      k = 0;
      do begin
        @(posedge i_clk);
        k++;
      end while (!(i_mont_done && mont_cnt - mb == exp_starts) && k < 20000);
      chk("last_done_seen", W'(k < 20000), W'(1));
      @(negedge i_clk);
      i_n = 33;
      i_y = 4;
      i_d = 7;
      i_start = 1;
      @(negedge i_clk);
      i_start = 0;
    end
    wait_fin(res);
    repeat (30) @(negedge i_clk);
    chk("one_finished_pulse", W'(fin_cnt - fb), W'(1));
    chk("one_prep_start", W'(prep_cnt - pb), W'(1));
    chk("result_held", o_result, res);
    ms = mont_cnt - mb;
    nq = neq_cnt - qb;
  endtask

  initial begin
    logic [W-1:0] res, n, y, d;
    int ms, nq, mb, pb;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", W'(o_busy), '0);
    chk("rst_finished", W'(o_finished), '0);
    chk("rst_prep_start", W'(o_prep_start), '0);
    chk("rst_mont_start", W'(o_mont_start), '0);
    chk("rst_result", o_result, '0);
    i_rst = 0;
    @(negedge i_clk);
    chk("prep_a_low", o_prep_a[W-1:0], '0);
    chk("prep_a_msb", W'(o_prep_a[W]), W'(1));
    chk("prep_k", W'(o_prep_k), W'(256));

    run_job(33, 5, 3, 0, 0, res, ms, nq);
    chk("j1_result", res, 26);
    chk("j1_mont_starts", W'(ms), W'(258));

    run_job(33, 7, 0, 0, 0, res, ms, nq);
    chk("d0_result", res, 1);
    chk("d0_mont_starts", W'(ms), W'(256));
    chk("d0_no_multiply", W'(nq), '0);

    run_job(33, 5, 3, 1, 0, res, ms, nq);
    chk("busy_start_result", res, 26);
    chk("busy_start_mont_starts", W'(ms), W'(258));

    run_job(33, 2, 5, 0, 1, res, ms, nq);
    chk("late_start_result", res, 32);
    chk("late_start_mont_starts", W'(ms), W'(258));

    prep_en = 0;
    mont_en = 0;
    pb = prep_cnt;
    mb = mont_cnt;
    start_job(33, 5, 3);
    wait_cnt(0, pb + 1, "rst_test_prep_start");
    prep_val = prep_f(5, 33);
    prep_req++;
    wait_cnt(1, mb + 1, "rst_test_mul_start");
    mont_val = mont_f(o_mont_a, o_mont_b, o_mont_n);
    mont_req++;
    wait_cnt(1, mb + 2, "rst_test_sqr_start");
    @(negedge i_clk);
    i_rst = 1;
    @(negedge i_clk);
    i_rst = 0;
    mont_val = rnd();
    mont_req++;
    pb = prep_cnt;
    mb = mont_cnt;
    repeat (6) @(negedge i_clk);
    chk("post_rst_busy", W'(o_busy), '0);
    chk("post_rst_finished", W'(o_finished), '0);
    chk("post_rst_result", o_result, '0);
    chk("post_rst_no_prep", W'(prep_cnt - pb), '0);
    chk("post_rst_no_mont", W'(mont_cnt - mb), '0);
    prep_en = 1;
    mont_en = 1;
    run_job(33, 2, 5, 0, 0, res, ms, nq);
    chk("post_rst_job_result", res, 32);

    prep_en = 0;
    mont_en = 0;
    mont_val = 3;
    mont_req++;
    repeat (3) @(negedge i_clk);
    mont_req++;
    repeat (3) @(negedge i_clk);
    pb = prep_cnt;
    mb = mont_cnt;
    start_job(33, 7, 6);
    wait_cnt(0, pb + 1, "spur_prep_start");
    mont_req++;
    repeat (4) @(negedge i_clk);
    chk("spur_no_mont_start", W'(mont_cnt - mb), '0);
    mont_en = 1;
    prep_val = prep_f(7, 33);
    prep_req++;
    wait_fin(res);
    chk("spur_job_result", res, modexp(33, 7, 6));
    prep_en = 1;

    max_lat = 4;
    for (int r = 0; r < 20; r++) begin
      n = rnd();
      n[0] = 1'b1;
      n[W-1] = 1'b1;
      y = rnd() % n;
      d = rnd();
      run_job(n, y, d, 0, 0, res, ms, nq);
      chk("rand_result", res, modexp(n, y, d));
      chk("rand_mont_starts", W'(ms), W'($countones(d) + W));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
